// File: rtl/vecunit_cla_pkg.sv
// Shared carry-lookahead definitions for the vecunit lane: default geometry, group count helper
// and the stage-1 payload carried between generate/propagate formation and carry resolution.
package vecunit_cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_GROUP = 4;

    function automatic int NGRP(input int width, input int group);
        return width / group;
    endfunction

    localparam int CLA_NGRP = NGRP(CLA_WIDTH, CLA_GROUP);

    // b_msb is the MSB of the effective (possibly inverted) B operand, not of b_i.
    typedef struct packed {
        logic [CLA_WIDTH-1:0] p;
        logic [CLA_WIDTH-1:0] g;
        logic [CLA_NGRP-1:0]  gg;
        logic [CLA_NGRP-1:0]  pg;
        logic                 c0;
        logic                 a_msb;
        logic                 b_msb;
    } s1_payload_t;

endpackage

// File: rtl/cla_group_carry.sv
// Combinational group-carry resolver: turns per-group G'/P' and the carry-in into the
// carry entering every group, plus the carry out of the last group.
module cla_group_carry
    import vecunit_cla_pkg::*;
#(
    parameter int N_GRP = CLA_NGRP
) (
    input  logic [N_GRP-1:0] i_gg,
    input  logic [N_GRP-1:0] i_pg,
    input  logic             i_c0,
    output logic [N_GRP:0]   o_c
);

    always_comb begin
        o_c    = '0;
        o_c[0] = i_c0;
        for (int k = 0; k < N_GRP; k++) begin
            o_c[k+1] = i_gg[k] | (i_pg[k] & o_c[k]);
        end
    end

endmodule

// File: rtl/gen_prop_unit.sv
// Per-group generate/propagate former: bit-level P/G plus the group-level G'/P' that feed
// the lookahead carry resolver.
module gen_prop_unit
    import vecunit_cla_pkg::*;
#(
    parameter int BITS = CLA_GROUP
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic [BITS-1:0] o_p,
    output logic [BITS-1:0] o_g,
    output logic            o_gg,
    output logic            o_pg
);

    assign o_p = i_a ^ i_b;
    assign o_g = i_a & i_b;

    always_comb begin
        o_gg = o_g[0];
        o_pg = o_p[0];
        for (int i = 1; i < BITS; i++) begin
            o_gg = o_g[i] | (o_p[i] & o_gg);
            o_pg = o_pg & o_p[i];
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor for one vector lane, with valid/ready
// on both sides. Stage 1 forms P/G, stage 2 resolves carries and registers sum/cout/ovf.
module cla_pipe_adder
    import vecunit_cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NG = NGRP(WIDTH, GROUP);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_pg;
    logic             w_c0;
    logic             w_accept;
    logic             w_s2_adv;

    s1_payload_t      r_s1;
    logic             r_s1_valid;

    logic [NG:0]      w_gc;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Stage 1 operand conditioning: subtraction is A + ~B + 1, so cin_i is ignored there.
    assign w_b_eff = sub_i ? ~b_i : b_i;
    assign w_c0    = sub_i | cin_i;

    for (genvar k = 0; k < NG; k++) begin : g_gp
        gen_prop_unit #(
            .BITS (GROUP)
        ) u_gen_prop (
            .i_a  (a_i[k*GROUP +: GROUP]),
            .i_b  (w_b_eff[k*GROUP +: GROUP]),
            .o_p  (w_p[k*GROUP +: GROUP]),
            .o_g  (w_g[k*GROUP +: GROUP]),
            .o_gg (w_gg[k]),
            .o_pg (w_pg[k])
        );
    end

    assign w_s2_adv   = r_s1_valid & (~r_s2_valid | out_ready_i);
    assign in_ready_o = ~r_s1_valid | w_s2_adv;
    assign w_accept   = in_valid_i & in_ready_o;

    // Payload only matters while r_s1_valid is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_s1.p     <= w_p;
            r_s1.g     <= w_g;
            r_s1.gg    <= w_gg;
            r_s1.pg    <= w_pg;
            r_s1.c0    <= w_c0;
            r_s1.a_msb <= a_i[WIDTH-1];
            r_s1.b_msb <= w_b_eff[WIDTH-1];
        end
    end

    cla_group_carry #(
        .N_GRP (NG)
    ) u_group_carry (
        .i_gg (r_s1.gg),
        .i_pg (r_s1.pg),
        .i_c0 (r_s1.c0),
        .o_c  (w_gc)
    );

    // Group boundaries take the lookahead carry; only bits inside a group ripple.
    always_comb begin
        w_c = '0;
        for (int k = 0; k < NG; k++) begin
            w_c[k*GROUP] = w_gc[k];
            for (int j = 0; j < GROUP - 1; j++) begin
                w_c[k*GROUP+j+1] = r_s1.g[k*GROUP+j] | (r_s1.p[k*GROUP+j] & w_c[k*GROUP+j]);
            end
        end
        w_c[WIDTH] = w_gc[NG];
    end

    assign w_sum = r_s1.p ^ w_c[WIDTH-1:0];

    // Same-sign operands with a sum of the other sign; equal to carry-in-MSB ^ carry-out.
    assign w_ovf = ~(r_s1.a_msb ^ r_s1.b_msb) & (r_s1.a_msb ^ w_sum[WIDTH-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_sum      <= w_sum;
                r_cout     <= w_c[WIDTH];
                r_ovf      <= w_ovf;
            end else if (out_ready_i) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign sum_o       = r_sum;
    assign cout_o      = r_cout;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: accepted beats push an arithmetic-model result,
// a negedge monitor pops and compares on every output handshake.
module tb_cla_pipe_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .ovf_o       (ovf)
    );

    // Plain integer arithmetic: unsigned sum gives sum/cout, signed sum that does not fit
    // in W bits is an overflow.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc, input logic ts);
        exp_t         e;
        longint       ua, ub, us, sa, sb, ss, wrapped;
        logic         c0;
        c0 = ts | tc;
        ua = longint'({32'b0, ta});
        ub = ts ? (longint'(64'h1_0000_0000) - 1 - longint'({32'b0, tb})) : longint'({32'b0, tb});
        us = ua + ub + longint'({63'b0, c0});
        e.sum  = us[W-1:0];
        e.cout = us[W];
        sa = longint'($signed(ta));
        sb = ts ? -longint'($signed(tb)) : longint'($signed(tb));
        ss = ts ? sa + sb : sa + sb + longint'({63'b0, c0});
        wrapped = longint'($signed(e.sum));
        e.ovf = (ss != wrapped);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                n_out++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got sum=%h cout=%b ovf=%b, none pending",
                             sum, cout, ovf);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                        errors++;
                        $display("FAIL result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Presents a beat and returns #1 after the edge that accepted it; in_valid stays high.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
        int n;
        n = 0;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic ts, input logic [W-1:0] es,
                           input logic ec, input logic eo);
        int lat;
        send(ta, tb, tc, ts);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd2);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_outputs(input string nm, input int target);
        int n;
        n = 0;
        while (n_out < target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_count"}, 32'(n_out), 32'(target));
        chk({nm, "_pending"}, 32'(q.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        logic done;
        logic [W-1:0] hold_sum;
        logic hold_cout, hold_ovf;

        // Reset held two cycles with a beat offered.
        rst = 1'b1;
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        idle(3);
        chk("rst_no_output", 32'(n_out), 32'd0);

        run_one("ripple",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("neg_ovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run_one("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_pos",  32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        run_one("sub_cin",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        run_one("add_cin",  32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        run_one("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        idle(3);

        // Six-beat stream with a three-cycle output stall after the first result.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom(), $urandom(), 1'($urandom_range(1)), 1'($urandom_range(1)));
                in_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("stall_first_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                hold_sum = sum;
                hold_cout = cout;
                hold_ovf = ovf;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_sum", sum, hold_sum);
                    chk("stall_cout_ovf", {30'b0, cout, ovf}, {30'b0, hold_cout, hold_ovf});
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_outputs("stream", base + 6);

        // Reset with both stages occupied; those beats must never come out.
        out_ready = 1'b0;
        send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
        send(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        base = n_out;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        idle(5);
        chk("midrst_discarded", 32'(n_out), 32'(base));
        run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        idle(3);

        // Random traffic with random backpressure.
        base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    send(rand_op(), rand_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_outputs("random", base + 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
